// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl
//
// Control FSM for a downstream 4-bit shift-register / down-counter stage.
// The block watches the serial data line for PATTERN, then raises shift_ena for
// exactly four cycles so the downstream stage captures the next four data bits
// (MSB first) as a delay value. It then issues one count_ena pulse every
// TICKS_PER_COUNT cycles until the downstream count reads zero. After that it
// holds done until ack is seen.
//
// Parameters
//   TICKS_PER_COUNT  clock cycles per unit of delay (2..65535)
//   PRE_W            prescaler width, 2**PRE_W >= TICKS_PER_COUNT
//   PATTERN          start sequence, first-received bit is the MSB
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   data       in   serial data, sampled every rising edge (also feeds downstream d)
//   q_in       in   [3:0] current downstream count value
//   ack        in   acknowledges done
//   shift_ena  out  downstream shift enable (registered)
//   count_ena  out  downstream decrement enable, single-cycle pulse
//   counting   out  high while counting down (registered)
//   done       out  high while waiting for ack (registered)

module timer_seq_ctrl #(
  parameter int unsigned TICKS_PER_COUNT = 1000,
  parameter int unsigned PRE_W           = 16,
  parameter logic [3:0]  PATTERN         = 4'b1101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data,
  input  logic [3:0] q_in,
  input  logic       ack,
  output logic       shift_ena,
  output logic       count_ena,
  output logic       counting,
  output logic       done
);

  // Elaboration-time parameter sanity checks.
  if (TICKS_PER_COUNT < 2 || TICKS_PER_COUNT > 65535) begin : g_bad_ticks
    $error("timer_seq_ctrl: TICKS_PER_COUNT out of range");
  end
  if (PRE_W < 2 || PRE_W > 31) begin : g_bad_prew
    $error("timer_seq_ctrl: PRE_W out of range");
  end else if ((64'd1 << PRE_W) < 64'(TICKS_PER_COUNT)) begin : g_small_prew
    $error("timer_seq_ctrl: PRE_W too narrow for TICKS_PER_COUNT");
  end

  localparam logic [PRE_W-1:0] PreMax = PRE_W'(TICKS_PER_COUNT - 1);

  // The four search states are encoded as the number of pattern bits matched
  // so far, so the search logic can move between them arithmetically.
  typedef enum logic [2:0] {
    StSearch0   = 3'd0,
    StSearch1   = 3'd1,
    StSearch11  = 3'd2,
    StSearch110 = 3'd3,
    StShift     = 3'd4,
    StCount     = 3'd5,
    StDone      = 3'd6
  } state_t;

  state_t           state_q;
  logic [1:0]       shift_cnt_q;
  logic [PRE_W-1:0] prescale_q;
  logic [2:0]       search_next;

  // Given `len` bits of PATTERN already matched and a new bit, return the
  // length of the longest suffix of the received stream that is still a
  // prefix of PATTERN (4 means a full match). This is what lets overlapping
  // occurrences such as 1,1,1,0,1 be detected.
  function automatic logic [2:0] match_next(input logic [2:0] len, input logic d_in);
    logic [3:0] seq;
    logic [3:0] mask;
    logic [2:0] best;
    // Matched prefix, right-aligned, with the new bit appended.
    seq  = ((PATTERN >> (3'd4 - len)) << 1) | {3'b000, d_in};
    best = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      mask = 4'b1111 >> (4 - k);
      if ((k <= int'(len) + 1) && ((seq & mask) == (PATTERN >> (4 - k)))) begin
        best = 3'(k);
      end
    end
    return best;
  endfunction

  assign search_next = match_next(state_q, data);

  // Decrement request: only on the last prescaler tick and only when the
  // downstream count is non-zero, so it can never wrap from 0 to 15.
  assign count_ena = (state_q == StCount) && (prescale_q == PreMax) && (q_in != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch0;
      shift_cnt_q <= 2'd0;
      prescale_q  <= '0;
      shift_ena   <= 1'b0;
      counting    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        StSearch0, StSearch1, StSearch11, StSearch110: begin
          if (search_next == 3'd4) begin
            state_q     <= StShift;
            shift_cnt_q <= 2'd0;
            shift_ena   <= 1'b1;
          end else begin
            state_q <= state_t'(search_next);
          end
        end

        StShift: begin
          // The downstream stage samples data on each of these four edges.
          shift_cnt_q <= shift_cnt_q + 2'd1;
          if (shift_cnt_q == 2'd3) begin
            state_q    <= StCount;
            prescale_q <= '0;
            shift_ena  <= 1'b0;
            counting   <= 1'b1;
          end
        end

        StCount: begin
          if (prescale_q == PreMax) begin
            prescale_q <= '0;
            if (q_in == 4'd0) begin
              state_q  <= StDone;
              counting <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            prescale_q <= prescale_q + 1'b1;
          end
        end

        StDone: begin
          if (ack) begin
            state_q <= StSearch0;
            done    <= 1'b0;
          end
        end

        default: begin
          state_q     <= StSearch0;
          shift_cnt_q <= 2'd0;
          prescale_q  <= '0;
          shift_ena   <= 1'b0;
          counting    <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Self-checking bench for timer_seq_ctrl. Contains a model of the downstream
// shift/down-counter stage, a behavioural reference model of the controller,
// a per-cycle compare process and directed scenarios with literal expectations.

module tb_timer_seq_ctrl;

  localparam int         T   = 4;
  localparam logic [3:0] PAT = 4'b1101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data;
  logic       ack;
  logic [3:0] q_in;
  logic       shift_ena;
  logic       count_ena;
  logic       counting;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  timer_seq_ctrl #(
    .TICKS_PER_COUNT(T),
    .PRE_W          (16),
    .PATTERN        (PAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .q_in     (q_in),
    .ack      (ack),
    .shift_ena(shift_ena),
    .count_ena(count_ena),
    .counting (counting),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Downstream stage: shift register / down counter, not reset by this block.
  logic [3:0] q_reg = 4'd0;
  assign q_in = q_reg;
  always @(posedge clk) begin
    if (shift_ena)      q_reg <= {q_reg[2:0], data};
    else if (count_ena) q_reg <= q_reg - 4'd1;
  end

  // Reference model: mode 0 search, 1 shift, 2 count, 3 done.
  // Detection = last four bits received since search began equal PAT.
  int         m_mode    = 0;
  logic [3:0] m_win     = 4'd0;
  int         m_nbits   = 0;
  int         m_shift_n = 0;
  logic [3:0] m_val     = 4'd0;
  int         m_elapsed = 0;
  logic [3:0] m_win_next;
  assign m_win_next = {m_win[2:0], data};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode    <= 0;
      m_win     <= 4'd0;
      m_nbits   <= 0;
      m_shift_n <= 0;
      m_val     <= 4'd0;
      m_elapsed <= 0;
    end else begin
      case (m_mode)
        0: begin
          m_win   <= m_win_next;
          m_nbits <= m_nbits + 1;
          if (m_nbits >= 3 && m_win_next == PAT) begin
            m_mode    <= 1;
            m_shift_n <= 0;
          end
        end
        1: begin
          m_val     <= {m_val[2:0], data};
          m_shift_n <= m_shift_n + 1;
          if (m_shift_n == 3) begin
            m_mode    <= 2;
            m_elapsed <= 0;
          end
        end
        2: begin
          m_elapsed <= m_elapsed + 1;
          if (m_elapsed + 1 == (int'(m_val) + 1) * T) m_mode <= 3;
        end
        default: begin
          if (ack) begin
            m_mode  <= 0;
            m_win   <= 4'd0;
            m_nbits <= 0;
          end
        end
      endcase
    end
  end

  logic exp_shift, exp_cena, exp_counting, exp_done;
  assign exp_shift    = (m_mode == 1);
  assign exp_counting = (m_mode == 2);
  assign exp_done     = (m_mode == 3);
  // A pulse closes each of the first m_val units of T cycles.
  assign exp_cena     = (m_mode == 2) && (m_elapsed % T == T - 1) && (m_elapsed / T < int'(m_val));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cumulative output activity, read by the scenarios as differences.
  int tot_shift  = 0;
  int tot_count  = 0;
  int tot_pulses = 0;

  always @(negedge clk) begin
    chk("shift_ena", int'(shift_ena), int'(exp_shift));
    chk("count_ena", int'(count_ena), int'(exp_cena));
    chk("counting",  int'(counting),  int'(exp_counting));
    chk("done",      int'(done),      int'(exp_done));
    if (count_ena) chk("no_wrap_q_nonzero", int'(q_in != 4'd0), 1);
    if (shift_ena) tot_shift  <= tot_shift + 1;
    if (counting)  tot_count  <= tot_count + 1;
    if (count_ena) tot_pulses <= tot_pulses + 1;
  end

  // Drive n bits MSB first; each returns 1 time unit after the sampling edge.
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data = bits[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while (!done && i < bound) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("done_within_bound", int'(done), 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("ack_clears_done", int'(done), 0);
  endtask

  int s_shift, s_count, s_pulses;

  task automatic snap();
    s_shift  = tot_shift;
    s_count  = tot_count;
    s_pulses = tot_pulses;
  endtask

  initial begin
    rst_n = 1'b0;
    data  = 1'b0;
    ack   = 1'b0;
    #1;
    chk("reset_outputs", int'({shift_ena, count_ena, counting, done}), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Load 2: pulses at COUNT cycles 4 and 8, done after 12.
    snap();
    send_bits(16'b1101, 4);
    chk("detect_1101", int'(shift_ena), 1);
    send_bits(16'b0010, 4);
    chk("enter_count", int'(counting), 1);
    chk("load_2", int'(q_in), 2);
    chk("shift_len", tot_shift - s_shift, 4);
    data = 1'b0;
    chk("no_pulse_cycle1", int'(count_ena), 0);
    idle(3);
    chk("pulse_cycle4", int'(count_ena), 1);
    wait_done(100);
    chk("pulses_load2", tot_pulses - s_pulses, 2);
    chk("count_len_load2", tot_count - s_count, 12);

    // Overlapping pattern, then load 0.
    do_ack();
    snap();
    send_bits(16'b1110, 4);
    chk("no_early_detect", int'(shift_ena), 0);
    send_bits(16'b1, 1);
    chk("overlap_detect", int'(shift_ena), 1);
    send_bits(16'b0000, 4);
    chk("load_0", int'(q_in), 0);
    wait_done(100);
    chk("pulses_load0", tot_pulses - s_pulses, 0);
    chk("count_len_load0", tot_count - s_count, 4);

    // Load 15.
    do_ack();
    snap();
    send_bits(16'b1101_1111, 8);
    chk("load_15", int'(q_in), 15);
    data = 1'b0;
    wait_done(200);
    chk("pulses_load15", tot_pulses - s_pulses, 15);
    chk("count_len_load15", tot_count - s_count, 64);
    chk("q_final_zero", int'(q_in), 0);

    // Pattern during DONE is ignored.
    snap();
    send_bits(16'b11_0100_0000, 10);
    chk("done_held", int'(done), 1);
    chk("no_shift_in_done", tot_shift - s_shift, 0);
    do_ack();
    send_bits(16'b1101, 4);
    chk("fresh_detect", int'(shift_ena), 1);

    // Reset between edges mid-SHIFT.
    send_bits(16'b00, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_shift", int'({shift_ena, count_ena, counting, done}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bits(16'b101, 3);
    chk("needs_full_pattern", int'(shift_ena), 0);
    send_bits(16'b1101, 4);
    chk("detect_after_reset1", int'(shift_ena), 1);
    send_bits(16'b0011, 4);
    data = 1'b0;

    // Reset between edges mid-COUNT.
    idle(5);
    chk("counting_before_reset", int'(counting), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_count", int'({shift_ena, count_ena, counting, done}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bits(16'b0110, 4);
    chk("no_detect_partial", int'(shift_ena), 0);
    send_bits(16'b1, 1);
    chk("detect_after_reset2", int'(shift_ena), 1);
    snap();
    send_bits(16'b0001, 4);
    data = 1'b0;
    wait_done(100);
    chk("pulses_load1", tot_pulses - s_pulses, 1);
    chk("count_len_load1", tot_count - s_count, 8);
    do_ack();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
- Control FSM that drives the downstream 4-bit shift-register/down-counter stage.
- Watches a serial data line for start pattern 1101, then asserts shift_ena for exactly 4 cycles so the downstream stage loads the next 4 bits (MSB first) as a delay value.
- Issues prescaled count_ena pulses until the downstream count reaches zero, then holds done until acknowledged.

Parameters:
- TICKS_PER_COUNT, 1000, clock cycles per unit of delay (legal range 2..65535).
- PRE_W, 16, prescaler width; must satisfy 2^PRE_W >= TICKS_PER_COUNT.
- PATTERN, 4'b1101, start sequence, first-received bit is the MSB.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  1  serial data, sampled every rising clk edge; also wired to the downstream d input.
- q_in  input  4  current count value from the downstream stage.
- ack  input  1  acknowledges done.
- shift_ena  output  1  downstream shift enable.
- count_ena  output  1  downstream decrement enable, 1-cycle pulse.
- counting  output  1  high while in COUNT.
- done  output  1  high while in DONE.

Behaviour:
- Reset: rst_n low forces state SEARCH0, pattern history empty, shift counter 0, prescaler 0. All outputs go to 0 immediately, with no clock needed. The block leaves reset on the first edge after rst_n rises.
- States: SEARCH0, SEARCH1, SEARCH11, SEARCH110, SHIFT, COUNT, DONE.
- Pattern search, overlap allowed, one transition per edge:
  - SEARCH0: data=1 goes to SEARCH1, else stays.
  - SEARCH1: data=1 goes to SEARCH11, else SEARCH0.
  - SEARCH11: data=0 goes to SEARCH110, else stays.
  - SEARCH110: data=1 goes to SHIFT, else SEARCH0.
- SHIFT:
  - shift_ena=1 for exactly 4 consecutive cycles. A 2-bit shift counter starts at 0 on entry.
  - After the 4th cycle the FSM goes to COUNT with prescaler=0.
  - The 4 data bits sampled on those edges go to the downstream stage; the first bit becomes q[3].
  - data is ignored by the FSM during SHIFT.
- COUNT:
  - counting=1. The prescaler increments every cycle.
  - When prescaler = TICKS_PER_COUNT-1 and q_in != 0: count_ena=1 for that cycle only, prescaler returns to 0, FSM stays in COUNT.
  - When prescaler = TICKS_PER_COUNT-1 and q_in = 0: go to DONE with count_ena=0.
  - count_ena=0 at all other times.
  - count_ena is a combinational decode of registered state, prescaler and q_in. It must never be asserted while q_in=0, so no wrap from 0 to 15 can occur.
  - Total COUNT duration = (q_in_loaded+1) * TICKS_PER_COUNT cycles.
- DONE:
  - done=1. ack sampled high at an edge goes to SEARCH0 with empty history.
  - data is ignored while in DONE; a pattern received during DONE does not start a new timer.
- ack outside DONE is ignored.
- shift_ena and count_ena are never high in the same cycle.
- counting and done are one-hot with the state; both are 0 in the SEARCH and SHIFT states.
- Mid-operation reset: rst_n low in any state aborts immediately to SEARCH0 with outputs 0. The downstream count value is not this block's responsibility.
- q_in changes while in SEARCH or DONE have no effect.

Test Plan:
- TICKS_PER_COUNT=4. Drive data 1,1,0,1 then 0,0,1,0 -> shift_ena high exactly for the 4 cycles after the pattern's last edge, and the downstream q loads 2. Then count_ena pulses at COUNT cycles 4 and 8, and done rises after 12 COUNT cycles.
- Overlap: data 1,1,1,0,1 -> the pattern is detected on the 5th bit, and shift_ena rises on the next cycle.
- Load value 0 (data 1,1,0,1,0,0,0,0) -> no count_ena pulse at all; done rises after exactly 4 COUNT cycles.
- Load value 15 with TICKS=4 -> 15 count_ena pulses, COUNT lasts 64 cycles, and q_in never wraps below 0.
- In DONE, hold ack=0 for 10 cycles while sending 1,1,0,1 -> done stays 1 and shift_ena stays 0. Then ack=1 for 1 cycle -> SEARCH0, and a fresh 1101 is detected normally.
- Assert rst_n=0 between clock edges mid-COUNT and mid-SHIFT -> all outputs are 0 before the next edge. After release, 1101 is required again before shift_ena rises.
